// File: rtl/consec_resp_checker_if.sv
// Signal bundle between the a/b/c waveform generators and the checker.
// The generator side drives the protocol signals; the checker drives results.
interface consec_resp_checker_if #(
    parameter int CNT_W = 8
);
    logic             disable_in;
    logic             a;
    logic             b;
    logic             c;
    logic             pass;
    logic             fail;
    logic             busy;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;

    modport master (
        output disable_in, a, b, c,
        input  pass, fail, busy, pass_count, fail_count
    );

    modport slave (
        input  disable_in, a, b, c,
        output pass, fail, busy, pass_count, fail_count
    );
endinterface

// File: rtl/consec_resp_checker.sv
// Run-time checker: rise of a -> b for B_LEN cycles -> c, overlapping attempts.
// Define CONSEC_RESP_CHECKER_COUNTERS_EN to build the saturating pass/fail counters.
module consec_resp_checker #(
    parameter int B_LEN = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    consec_resp_checker_if.slave  bus
);
    logic             a_prev_q, a_prev_d;
    logic [B_LEN:0]   st_q, st_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             rose;

    // st[k] marks an attempt whose rise was k+1 cycles ago.
    always_comb begin
        a_prev_d = bus.a;
        rose     = bus.a & ~a_prev_q & ~bus.disable_in;
        st_d     = '0;
        pass_d   = 1'b0;
        fail_d   = 1'b0;
        if (!bus.disable_in) begin
            st_d[0] = rose;
            for (int k = 0; k < B_LEN; k++) begin
                if (st_q[k]) begin
                    if (bus.b) st_d[k+1] = 1'b1;
                    else       fail_d    = 1'b1;
                end
            end
            if (st_q[B_LEN]) begin
                if (bus.c) pass_d = 1'b1;
                else       fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_prev_q <= 1'b0;
            st_q     <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            a_prev_q <= a_prev_d;
            st_q     <= st_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.pass = pass_q;
    assign bus.fail = fail_q;
    assign bus.busy = |st_q;

`ifdef CONSEC_RESP_CHECKER_COUNTERS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    // Counting on the _d pulse keeps count and pulse visible in the same cycle.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (pass_d && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + CNT_ONE;
        if (fail_d && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign bus.pass_count = pass_cnt_q;
    assign bus.fail_count = fail_cnt_q;
`else
    assign bus.pass_count = '0;
    assign bus.fail_count = '0;
`endif
endmodule

// File: tb/tb_consec_resp_checker.sv
// Directed bench for consec_resp_checker with a history-based protocol model.
// Works with or without CONSEC_RESP_CHECKER_COUNTERS_EN.
module tb_consec_resp_checker;
    localparam int B_LEN = 2;
    localparam int CNT_W = 8;
    localparam int HMAX  = 4096;
    localparam int CMAX  = 255;
`ifdef CONSEC_RESP_CHECKER_COUNTERS_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;

    consec_resp_checker_if #(.CNT_W(CNT_W)) bus ();

    consec_resp_checker #(
        .B_LEN(B_LEN),
        .CNT_W(CNT_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;
    int n    = 0;
    bit run  = 1'b0;

    bit a_h [HMAX];
    bit b_h [HMAX];
    bit c_h [HMAX];
    bit d_h [HMAX];
    bit r_h [HMAX];
    int pc_m = 0;
    int fc_m = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---- model: outputs after edge m, derived from the input history ----
    function automatic bit rose_at(int s);
        bit ap;
        if (s < 0) return 1'b0;
        ap = (s == 0 || r_h[s-1]) ? 1'b0 : a_h[s-1];
        return a_h[s] & ~ap & ~d_h[s];
    endfunction

    function automatic bit clean(int s, int m);
        if (s < 0) return 1'b0;
        for (int i = s; i <= m; i++)
            if (d_h[i] || r_h[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit b_all(int lo, int hi);
        for (int i = lo; i <= hi; i++)
            if (!b_h[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_pass(int m);
        int s = m - B_LEN - 1;
        if (!rose_at(s) || !clean(s, m)) return 1'b0;
        return b_all(s + 1, s + B_LEN) && c_h[m];
    endfunction

    function automatic bit exp_fail(int m);
        for (int j = 1; j <= B_LEN + 1; j++) begin
            int s = m - j;
            if (rose_at(s) && clean(s, m) && b_all(s + 1, m - 1)) begin
                if (j <= B_LEN && !b_h[m]) return 1'b1;
                if (j == B_LEN + 1 && !c_h[m]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit exp_busy(int m);
        for (int k = 0; k <= B_LEN; k++) begin
            int s = m - k;
            if (rose_at(s) && clean(s, m) && b_all(s + 1, m)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---- per-cycle compare process ----
    always @(posedge clock) begin
        if (run) begin
            bit ep, ef, eb;
            a_h[n] = bus.a;
            b_h[n] = bus.b;
            c_h[n] = bus.c;
            d_h[n] = bus.disable_in;
            r_h[n] = ~reset_n;
            #1;
            if (r_h[n]) begin
                ep = 1'b0; ef = 1'b0; eb = 1'b0;
                pc_m = 0; fc_m = 0;
            end else begin
                ep = exp_pass(n);
                ef = exp_fail(n);
                eb = exp_busy(n);
                if (ep && pc_m < CMAX) pc_m++;
                if (ef && fc_m < CMAX) fc_m++;
            end
            chk("pass", {31'd0, bus.pass}, {31'd0, ep});
            chk("fail", {31'd0, bus.fail}, {31'd0, ef});
            chk("busy", {31'd0, bus.busy}, {31'd0, eb});
            chk("pass_count", {24'd0, bus.pass_count}, CEN ? pc_m : 0);
            chk("fail_count", {24'd0, bus.fail_count}, CEN ? fc_m : 0);
            n++;
        end
    end

    // One cycle of stimulus; returns at the following negedge.
    task automatic cyc(input bit ia, input bit ib, input bit ic,
                       input bit id, input bit rn);
        bus.a          = ia;
        bus.b          = ib;
        bus.c          = ic;
        bus.disable_in = id;
        reset_n        = rn;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 1);
    endtask

    initial begin
        bus.a = 0; bus.b = 0; bus.c = 0; bus.disable_in = 0;
        reset_n = 0;
        run = 1'b1;

        // clean pass: a@1, b@2-3, c@4 -> pass visible at 5
        cyc(0, 0, 0, 0, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_pcnt", {24'd0, bus.pass_count}, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        chk("t1_busy", {31'd0, bus.busy}, 1);
        cyc(0, 0, 1, 0, 1);
        chk("t1_pass", {31'd0, bus.pass}, 1);
        chk("t1_pcnt", {24'd0, bus.pass_count}, CEN ? 1 : 0);
        cyc(0, 0, 0, 0, 1);
        chk("t1_pass_off", {31'd0, bus.pass}, 0);

        // b drops: a@6, b@7, b low @8 -> fail visible at 9
        cyc(1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t2_fail", {31'd0, bus.fail}, 1);
        chk("t2_fcnt", {24'd0, bus.fail_count}, CEN ? 1 : 0);
        chk("t2_pass", {31'd0, bus.pass}, 0);
        idle(2);

        // overlap: rise@1 fails on c@4, rise@3 passes on c@6
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        chk("t3_fail", {31'd0, bus.fail}, 1);
        cyc(0, 1, 0, 0, 1);
        chk("t3_quiet", {31'd0, bus.fail | bus.pass}, 0);
        cyc(0, 0, 1, 0, 1);
        chk("t3_pass", {31'd0, bus.pass}, 1);
        idle(1);

        // disable kills in-flight attempt, counters hold
        cyc(1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 1, 1);
        chk("t4_busy", {31'd0, bus.busy}, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t4_nofail", {31'd0, bus.fail}, 0);
        chk("t4_pcnt", {24'd0, bus.pass_count}, CEN ? 1 : 0);
        chk("t4_fcnt", {24'd0, bus.fail_count}, CEN ? 1 : 0);
        // a rising while disabled is not a rise afterwards either
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 1);
        chk("t4_no_rise", {31'd0, bus.busy}, 0);
        idle(3);

        // reset mid-attempt; a held high across release counts as a rise
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 0);
        chk("t5_rst", {29'd0, bus.busy, bus.pass, bus.fail}, 0);
        cyc(1, 1, 0, 0, 1);
        chk("t5_rise", {31'd0, bus.busy}, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 1);
        chk("t5_pass", {31'd0, bus.pass}, 1);
        chk("t5_pcnt", {24'd0, bus.pass_count}, CEN ? 1 : 0);
        idle(2);

        // 260 failing attempts -> fail_count saturates
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            cyc(1, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 1);
            if (i == 99)
                chk("t6_fcnt100", {24'd0, bus.fail_count}, CEN ? 100 : 0);
        end
        idle(2);
        chk("t6_fcnt_sat", {24'd0, bus.fail_count}, CEN ? 255 : 0);
        chk("t6_pcnt", {24'd0, bus.pass_count}, 0);

        // mixed overlapping traffic, checked by the model only
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++)
            cyc(i % 3 == 0, i % 7 != 3, i % 5 != 0, i % 17 == 16, 1);
        idle(4);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
